rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
//   Round-robin arbiter that shares one muxBus4 8:1 x 4-bit selector among N
//   requesters. It drives the mux select, captures the selected word into an
//   output register, and presents it downstream with a valid/ready handshake.
//   It sits between the requester bank (packed bus into muxBus4) and the
//   single consumer of the mux output.
// PARAMETERS
//   N     8   number of requesters; power of 2, >= 2
//   W     4   data width per requester; must match the mux word width
//   SELW  3   select width; must equal log2(N)
// PORTS
//   clk        in   1     clock, all state updates on rising edge
//   reset      in   1     synchronous, active-high
//   req        in   N     req[i]=1: requester i has a word on mux input i
//   mux_sel    out  SELW  select to muxBus4 (combinational, see below)
//   mux_out    in   W     muxBus4 output for mux_sel
//   gnt        out  N     one-hot, 1-cycle pulse: word of requester i taken this edge
//   out_data   out  W     registered captured word
//   out_src    out  SELW  registered index of requester that produced out_data
//   out_valid  out  1     out_data/out_src valid
//   out_ready  in   1     consumer accepts when out_valid & out_ready
// BEHAVIOUR
//   - Reset (sync, active-high): state=IDLE, ptr=0, out_valid=0, out_data=0,
//     out_src=0, gnt=0, held select=0. Reset wins over every other event,
//     including one mid-transfer; the pending word is discarded.
//   - ptr = highest-priority index. Winner = first i with req[i]=1 scanning
//     ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N wrap-around).
//   - take = any(req) & (state==IDLE | (out_valid & out_ready)).
//   - mux_sel = winner when take, else the held select (last winner).
//     Combinational from req/state/out_ready; no path from mux_out.
//   - On a take edge: out_data<=mux_out; out_src<=winner; out_valid<=1;
//     ptr<=(winner+1) mod N; held select<=winner; state<=BUSY.
//     gnt[winner]=1 combinationally in that cycle, all other bits 0.
//   - FSM:
//     IDLE -> BUSY on take.
//     BUSY: if out_ready & no req -> IDLE, out_valid<=0.
//     BUSY: if out_ready & req -> stay BUSY, capture next winner (back-to-back).
//     BUSY: if !out_ready -> hold; out_data/out_src stable, gnt=0.
//   - Throughput: 1 word/cycle while out_ready=1 and req!=0.
//     Latency: req to out_valid is 1 cycle.
//   - Requester protocol: word must be stable on the mux while req=1. The
//     requester drops req or presents its next word on the cycle after gnt.
//     The arbiter never samples mux_out for an index whose req=0.
//   - A req that drops while not granted is simply not served. A req change
//     in BUSY does not alter the held out_data.
//   - Single requester continuously asserting with out_ready=1: granted
//     every cycle. Fairness: any asserted req is served within N grants.
// TESTING
//   1 Reset: reset=1 for 2 cycles with req=8'hFF -> out_valid=0, gnt=0, out_data=0,
//     and ptr=0 (first post-reset grant goes to index 0).
//   2 Words {12,15,1,3,5,2,11,14} on inputs 0..7, req=8'hFF, out_ready=1 -> outputs
//     out_src 0..7 in order, data 12,15,1,3,5,2,11,14, then wraps to 0.
//     One word per cycle.
//   3 Backpressure: with req=8'b0010_1000, hold out_ready=0 for 5 cycles -> out_src=3,
//     out_data=3 held stable, gnt=0. Raise out_ready -> next output is src 5, data 2.
//   4 Wrap priority: last grant=6, req=8'b0100_0001 -> winner 0; the next winner is 6.
//   5 Idle return: single req[7] pulsed for 1 cycle, out_ready=1 -> one transfer with
//     data 14, gnt[7] pulse, then out_valid=0 and state=IDLE.
//   6 Reset mid-operation: out_valid=1, out_ready=0, reset=1 for 1 cycle -> out_valid=0
//     next edge; after release, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/rr_mux_arbiter_if.sv
// rtl/rr_mux_arbiter_if.sv - requester/mux/consumer bus for rr_mux_arbiter
//
// Purpose: bundles the requester bank, the shared mux select/output and the
// downstream valid/ready handshake of the round-robin mux arbiter.
// Signals:
//   req       N     requester i has a word on mux input i
//   mux_sel   SELW  select driven into the shared mux
//   mux_out   W     shared mux output for mux_sel
//   gnt       N     one-hot pulse, word of requester i taken this edge
//   out_data  W     captured word
//   out_src   SELW  index of requester that produced out_data
//   out_valid 1     out_data/out_src valid
//   out_ready 1     consumer accepts when out_valid & out_ready
// Modports: master = arbiter side, slave = environment side.
interface rr_mux_arbiter_if #(
  parameter int N    = 8,
  parameter int W    = 4,
  parameter int SELW = 3
);
  logic [N-1:0]    req;
  logic [SELW-1:0] mux_sel;
  logic [W-1:0]    mux_out;
  logic [N-1:0]    gnt;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_src;
  logic            out_valid;
  logic            out_ready;

  modport master (
    input  req,
    input  mux_out,
    input  out_ready,
    output mux_sel,
    output gnt,
    output out_data,
    output out_src,
    output out_valid
  );

  modport slave (
    output req,
    output mux_out,
    output out_ready,
    input  mux_sel,
    input  gnt,
    input  out_data,
    input  out_src,
    input  out_valid
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter sharing one N:1 mux among N requesters
//
// Purpose: picks one requester per cycle in round-robin order, steers the
// shared mux to it, captures the selected word into an output register and
// presents it downstream with a valid/ready handshake.
// Ports:
//   clk    in  clock, all state updates on rising edge
//   reset  in  synchronous, active-high; discards any pending word
//   bus    master modport of rr_mux_arbiter_if (req, mux_sel, mux_out, gnt,
//          out_data, out_src, out_valid, out_ready)
module rr_mux_arbiter #(
  parameter int N    = 8,
  parameter int W    = 4,
  parameter int SELW = 3
) (
  input  logic              clk,
  input  logic              reset,
  rr_mux_arbiter_if.master  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] held_q, held_d;
  logic [SELW-1:0] src_q, src_d;
  logic [W-1:0]    data_q, data_d;
  logic            valid_q, valid_d;

  logic [SELW-1:0] winner;
  logic [SELW-1:0] idx;
  logic            any_req;
  logic            take;

  // Scan offsets from far to near so the nearest requester at or after ptr
  // is the last assignment and therefore wins. Index arithmetic wraps
  // naturally because N is a power of two.
  always_comb begin
    winner  = ptr_q;
    idx     = ptr_q;
    any_req = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr_q + SELW'(k);
      if (bus.req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  // Reset is folded in so nothing is reported as taken on a reset edge.
  assign take = any_req & ~reset &
                ((state_q == IDLE) | (valid_q & bus.out_ready));

  always_comb begin
    bus.gnt = '0;
    if (take) begin
      bus.gnt[winner] = 1'b1;
    end
  end

  // Hold the last winner when idle or stalled so the mux input stays put.
  assign bus.mux_sel = take ? winner : held_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    held_d  = held_q;
    src_d   = src_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (take) begin
      data_d  = bus.mux_out;
      src_d   = winner;
      valid_d = 1'b1;
      ptr_d   = winner + SELW'(1);
      held_d  = winner;
      state_d = BUSY;
    end else if ((state_q == BUSY) && bus.out_ready) begin
      // Word consumed and nobody waiting.
      valid_d = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      held_q  <= '0;
      src_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      held_q  <= held_d;
      src_q   <= src_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed self-checking bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [3:0] words [8];

  rr_mux_arbiter_if #(.N(8), .W(4), .SELW(3)) bus ();

  rr_mux_arbiter #(.N(8), .W(4), .SELW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural stand-in for the shared 8:1 x 4-bit mux.
  assign bus.mux_out = words[bus.mux_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int src, input int data);
    check({tag, " valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, " src"},   32'(bus.out_src),   32'(src));
    check({tag, " data"},  32'(bus.out_data),  32'(data));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    words[0] = 4'd12; words[1] = 4'd15; words[2] = 4'd1;  words[3] = 4'd3;
    words[4] = 4'd5;  words[5] = 4'd2;  words[6] = 4'd11; words[7] = 4'd14;

    // 1: reset with all requests asserted
    reset = 1'b1;
    bus.req = 8'hFF;
    bus.out_ready = 1'b1;
    step();
    step();
    check("rst valid", 32'(bus.out_valid), 32'd0);
    check("rst data",  32'(bus.out_data),  32'd0);
    check("rst src",   32'(bus.out_src),   32'd0);
    check("rst gnt",   32'(bus.gnt),       32'd0);
    reset = 1'b0;
    #1;

    // 2: full round-robin sweep, one word per cycle, then wrap to 0
    for (int i = 0; i < 8; i++) begin
      check($sformatf("sweep gnt%0d", i), 32'(bus.gnt), 32'(8'(1) << i));
      check($sformatf("sweep sel%0d", i), 32'(bus.mux_sel), 32'(i));
      step();
      check_out($sformatf("sweep %0d", i), i, int'(words[i]));
    end
    check("wrap gnt", 32'(bus.gnt), 32'h01);
    step();
    check_out("wrap", 0, 12);

    // 3: backpressure holds the captured word
    bus.req = 8'b0010_1000;
    #1;
    check("bp gnt3", 32'(bus.gnt), 32'h08);
    step();
    check_out("bp first", 3, 3);
    bus.out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp gnt0 %0d", i), 32'(bus.gnt), 32'd0);
      check($sformatf("bp sel %0d", i), 32'(bus.mux_sel), 32'd3);
      step();
      check_out($sformatf("bp hold %0d", i), 3, 3);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp gnt5", 32'(bus.gnt), 32'h20);
    step();
    check_out("bp next", 5, 2);

    // 4: wrap-around priority after a grant to 6
    bus.req = 8'b0100_0000;
    step();
    check_out("wp 6", 6, 11);
    bus.req = 8'b0100_0001;
    #1;
    check("wp gnt0", 32'(bus.gnt), 32'h01);
    step();
    check_out("wp 0", 0, 12);
    check("wp gnt6", 32'(bus.gnt), 32'h40);
    step();
    check_out("wp 6b", 6, 11);

    // 5: drain, then a single one-cycle request from 7
    bus.req = 8'h00;
    step();
    check("drain valid", 32'(bus.out_valid), 32'd0);
    bus.req = 8'h80;
    #1;
    check("idle gnt7", 32'(bus.gnt), 32'h80);
    step();
    bus.req = 8'h00;
    #1;
    check_out("idle 7", 7, 14);
    check("idle gnt off", 32'(bus.gnt), 32'd0);
    step();
    check("idle valid", 32'(bus.out_valid), 32'd0);
    // A take with out_ready low is only possible from IDLE.
    bus.out_ready = 1'b0;
    bus.req = 8'h01;
    #1;
    check("idle state", 32'(bus.gnt), 32'h01);
    step();
    check_out("idle 0", 0, 12);

    // 6: reset while a word is pending; ptr would otherwise favour 7
    bus.req = 8'h81;
    reset = 1'b1;
    #1;
    check("mrst gnt", 32'(bus.gnt), 32'd0);
    step();
    check("mrst valid", 32'(bus.out_valid), 32'd0);
    check("mrst data",  32'(bus.out_data),  32'd0);
    check("mrst src",   32'(bus.out_src),   32'd0);
    reset = 1'b0;
    #1;
    check("mrst gnt0", 32'(bus.gnt), 32'h01);
    check("mrst sel0", 32'(bus.mux_sel), 32'd0);
    step();
    check_out("mrst 0", 0, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
